// File: rtl/layer_color_mapper.sv
// layer_color_mapper
//   Picks the highest-priority opaque sprite layer for each pixel, looks its colour up in a
//   per-layer palette and drives a registered RGB pixel. An optional hit-flash per layer inverts
//   that layer's colour on alternating frames.
//
// Ports
//   Clk          sole clock, rising edge
//   Reset        synchronous, active-high
//   frame_start  one-cycle pulse at start of frame (steps the flash counters)
//   blank        pixel outside visible area, aligned with layer_hit
//   layer_hit    per-layer bounding-box hit
//   layer_idx    per-layer palette index, ROM_LAT cycles after layer_hit
//   pal_we       palette write strobe
//   pal_addr     palette write address {layer, idx}
//   pal_wdata    palette write data (RGB)
//   flash_req    per-layer flash start
//   flash_busy   per-layer flash counter nonzero (registered)
//   VGA_R/G/B    registered pixel colour, ROM_LAT+2 cycles after hit/blank

module layer_color_mapper #(
    parameter int unsigned NUM_LAYERS   = 4,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned ROM_LAT      = 2,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter logic [23:0] BG_COLOR     = 24'h0000FF,
    localparam int unsigned SEL_W       = $clog2(NUM_LAYERS),
    localparam int unsigned ADDR_W      = SEL_W + IDX_W
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        frame_start,
    input  logic                        blank,
    input  logic [NUM_LAYERS-1:0]       layer_hit,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic                        pal_we,
    input  logic [ADDR_W-1:0]           pal_addr,
    input  logic [23:0]                 pal_wdata,
    input  logic [NUM_LAYERS-1:0]       flash_req,
    output logic [NUM_LAYERS-1:0]       flash_busy,
    output logic [7:0]                  VGA_R,
    output logic [7:0]                  VGA_G,
    output logic [7:0]                  VGA_B
);

    // Layer-number registers need at least one bit even for a single layer.
    localparam int unsigned LYR_W      = (SEL_W > 0) ? SEL_W : 1;
    localparam int unsigned PAL_DEPTH  = 1 << ADDR_W;
    localparam logic [7:0]  FLASH_LOAD = 8'(FLASH_FRAMES);

    // ------------------------------------------------------------------
    // Align hit/blank with the sprite-ROM index
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] hit_al;
    logic                  blank_al;

    generate
        if (ROM_LAT == 0) begin : g_no_dly
            assign hit_al   = layer_hit;
            assign blank_al = blank;
        end else begin : g_dly
            logic [NUM_LAYERS-1:0] hit_pipe_q [ROM_LAT];
            logic [ROM_LAT-1:0]    blank_pipe_q;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    for (int i = 0; i < ROM_LAT; i++) begin
                        hit_pipe_q[i] <= '0;
                    end
                    blank_pipe_q <= '0;
                end else begin
                    hit_pipe_q[0]   <= layer_hit;
                    blank_pipe_q[0] <= blank;
                    for (int i = 1; i < ROM_LAT; i++) begin
                        hit_pipe_q[i]   <= hit_pipe_q[i-1];
                        blank_pipe_q[i] <= blank_pipe_q[i-1];
                    end
                end
            end

            assign hit_al   = hit_pipe_q[ROM_LAT-1];
            assign blank_al = blank_pipe_q[ROM_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: priority select of the lowest-numbered opaque layer
    // ------------------------------------------------------------------
    logic             win_found;
    logic [LYR_W-1:0] win_layer;
    logic [IDX_W-1:0] win_idx;

    always_comb begin
        win_found = 1'b0;
        win_layer = '0;
        win_idx   = '0;
        // Walk from the lowest priority upward so the last hit assigned wins.
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (hit_al[k] && (layer_idx[k*IDX_W +: IDX_W] != '0)) begin
                win_found = 1'b1;
                win_layer = LYR_W'(k);
                win_idx   = layer_idx[k*IDX_W +: IDX_W];
            end
        end
    end

    logic             s1_any_q;
    logic             s1_blank_q;
    logic [LYR_W-1:0] s1_layer_q;
    logic [IDX_W-1:0] s1_idx_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_any_q   <= 1'b0;
            s1_blank_q <= 1'b0;
            s1_layer_q <= '0;
            s1_idx_q   <= '0;
        end else begin
            s1_any_q   <= win_found;
            s1_blank_q <= blank_al;
            s1_layer_q <= win_layer;
            s1_idx_q   <= win_idx;
        end
    end

    // ------------------------------------------------------------------
    // Palette: asynchronous read, so a write on the reading edge yields old data
    // ------------------------------------------------------------------
    logic [23:0]       pal_mem [PAL_DEPTH];
    logic [ADDR_W-1:0] pal_rd_addr;
    logic [23:0]       pal_rd_data;

    // Contents deliberately survive Reset; writes are blocked while it is held.
    always_ff @(posedge Clk) begin
        if (pal_we && !Reset) begin
            pal_mem[pal_addr] <= pal_wdata;
        end
    end

    assign pal_rd_addr = (ADDR_W'(s1_layer_q) << IDX_W) | ADDR_W'(s1_idx_q);
    assign pal_rd_data = pal_mem[pal_rd_addr];

    // ------------------------------------------------------------------
    // Flash counters: load beats decrement, saturate at zero
    // ------------------------------------------------------------------
    logic [7:0]            flash_cnt_q [NUM_LAYERS];
    logic [7:0]            flash_cnt_d [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] flash_busy_q;

    always_comb begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
            flash_cnt_d[k] = flash_cnt_q[k];
            if (flash_req[k]) begin
                flash_cnt_d[k] = FLASH_LOAD;
            end else if (frame_start && (flash_cnt_q[k] != 8'd0)) begin
                flash_cnt_d[k] = flash_cnt_q[k] - 8'd1;
            end
        end
    end

    // flash_busy is built from the next count so it tracks the counter register exactly.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                flash_cnt_q[k] <= 8'd0;
            end
            flash_busy_q <= '0;
        end else begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                flash_cnt_q[k]  <= flash_cnt_d[k];
                flash_busy_q[k] <= (flash_cnt_d[k] != 8'd0);
            end
        end
    end

    assign flash_busy = flash_busy_q;

    // ------------------------------------------------------------------
    // Stage 2: colour select and output register
    // ------------------------------------------------------------------
    logic        win_invert;
    logic [23:0] color_d;
    logic [23:0] color_q;

    // Odd count implies nonzero, so bit 0 alone selects the inverted frames.
    assign win_invert = flash_cnt_q[s1_layer_q][0];

    always_comb begin
        color_d = BG_COLOR;
        if (s1_blank_q) begin
            color_d = 24'h000000;
        end else if (s1_any_q) begin
            color_d = win_invert ? ~pal_rd_data : pal_rd_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            color_q <= BG_COLOR;
        end else begin
            color_q <= color_d;
        end
    end

    assign VGA_R = color_q[23:16];
    assign VGA_G = color_q[15:8];
    assign VGA_B = color_q[7:0];

endmodule

// File: tb/tb_layer_color_mapper.sv
// Directed bench for layer_color_mapper (4 layers, 4-bit index, ROM_LAT=2, FLASH_FRAMES=3).
module tb_layer_color_mapper;

    localparam logic [23:0] BG = 24'h0000FF;

    logic        Clk         = 1'b0;
    logic        Reset       = 1'b1;
    logic        frame_start = 1'b0;
    logic        blank       = 1'b0;
    logic [3:0]  layer_hit   = '0;
    logic [15:0] layer_idx   = '0;
    logic        pal_we      = 1'b0;
    logic [5:0]  pal_addr    = '0;
    logic [23:0] pal_wdata   = '0;
    logic [3:0]  flash_req   = '0;
    logic [3:0]  flash_busy;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic [23:0] vga;

    int n_checks = 0;
    int n_pass   = 0;

    assign vga = {VGA_R, VGA_G, VGA_B};

    always #5 Clk = ~Clk;

    layer_color_mapper #(
        .NUM_LAYERS  (4),
        .IDX_W       (4),
        .ROM_LAT     (2),
        .FLASH_FRAMES(3),
        .BG_COLOR    (24'h0000FF)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .blank      (blank),
        .layer_hit  (layer_hit),
        .layer_idx  (layer_idx),
        .pal_we     (pal_we),
        .pal_addr   (pal_addr),
        .pal_wdata  (pal_wdata),
        .flash_req  (flash_req),
        .flash_busy (flash_busy),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic pal_write(input logic [5:0] addr, input logic [23:0] data);
        pal_we    = 1'b1;
        pal_addr  = addr;
        pal_wdata = data;
        tick();
        pal_we = 1'b0;
    endtask

    // One isolated pixel: hit/blank at step 0, index at step 2, colour 4 edges later.
    // Optionally writes the palette on the edge where stage 2 reads it.
    task automatic pixel(input string tag, input logic [3:0] hit, input logic b,
                         input logic [15:0] idx, input logic [23:0] exp,
                         input logic wr, input logic [5:0] wa, input logic [23:0] wd);
        layer_hit = hit;
        blank     = b;
        tick();
        layer_hit = '0;
        blank     = 1'b0;
        tick();
        layer_idx = idx;
        tick();
        layer_idx = '0;
        check({tag, " pre"}, 32'(vga), 32'(BG));
        if (wr) begin
            pal_we    = 1'b1;
            pal_addr  = wa;
            pal_wdata = wd;
        end
        tick();
        pal_we = 1'b0;
        check(tag, 32'(vga), 32'(exp));
        tick();
        check({tag, " post"}, 32'(vga), 32'(BG));
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(); tick(); tick();
        check("rst_vga", 32'(vga), 32'(BG));
        check("rst_busy", 32'(flash_busy), 32'h0);
        Reset = 1'b0;
        tick();
        check("post_rst_vga", 32'(vga), 32'(BG));

        pal_write(6'h13, 24'h123456);
        pal_write(6'h05, 24'hA1B2C3);
        pal_write(6'h27, 24'h445566);

        // Latency, priority, transparency, blank
        pixel("latency",   4'b0010, 1'b0, 16'h0030, 24'h123456, 1'b0, 6'h0, 24'h0);
        pixel("priority",  4'b0101, 1'b0, 16'h0705, 24'hA1B2C3, 1'b0, 6'h0, 24'h0);
        pixel("transp",    4'b0101, 1'b0, 16'h0700, 24'h445566, 1'b0, 6'h0, 24'h0);
        pixel("all_zero",  4'b0101, 1'b0, 16'h0000, BG,         1'b0, 6'h0, 24'h0);
        pixel("no_hit",    4'b0000, 1'b0, 16'hFFFF, BG,         1'b0, 6'h0, 24'h0);
        pixel("blank",     4'b0001, 1'b1, 16'h0005, 24'h000000, 1'b0, 6'h0, 24'h0);

        // Flash on layer 0: counts 3,2,1,0 -> invert, normal, invert, normal
        flash_req = 4'b0001;
        tick();
        flash_req = '0;
        check("fl_busy3", 32'(flash_busy), 32'h1);
        pixel("fl_cnt3", 4'b0001, 1'b0, 16'h0005, 24'h5E4D3C, 1'b0, 6'h0, 24'h0);
        pixel("fl_other_layer", 4'b0010, 1'b0, 16'h0030, 24'h123456, 1'b0, 6'h0, 24'h0);
        frame_pulse();
        check("fl_busy2", 32'(flash_busy), 32'h1);
        pixel("fl_cnt2", 4'b0001, 1'b0, 16'h0005, 24'hA1B2C3, 1'b0, 6'h0, 24'h0);
        frame_pulse();
        check("fl_busy1", 32'(flash_busy), 32'h1);
        pixel("fl_cnt1", 4'b0001, 1'b0, 16'h0005, 24'h5E4D3C, 1'b0, 6'h0, 24'h0);
        frame_pulse();
        check("fl_busy0", 32'(flash_busy), 32'h0);
        pixel("fl_cnt0", 4'b0001, 1'b0, 16'h0005, 24'hA1B2C3, 1'b0, 6'h0, 24'h0);
        frame_pulse();
        check("fl_saturate", 32'(flash_busy), 32'h0);

        // Load wins over a coincident frame_start: counter restarts at 3
        flash_req   = 4'b0001;
        frame_start = 1'b1;
        tick();
        flash_req   = '0;
        frame_start = 1'b0;
        check("fl_reload_busy", 32'(flash_busy), 32'h1);
        pixel("fl_reload3", 4'b0001, 1'b0, 16'h0005, 24'h5E4D3C, 1'b0, 6'h0, 24'h0);
        frame_pulse();
        pixel("fl_reload2", 4'b0001, 1'b0, 16'h0005, 24'hA1B2C3, 1'b0, 6'h0, 24'h0);
        frame_pulse();
        frame_pulse();
        check("fl_reload_done", 32'(flash_busy), 32'h0);

        // Palette write on the edge stage 2 reads the same entry
        pixel("coll_old", 4'b0001, 1'b0, 16'h0005, 24'hA1B2C3, 1'b1, 6'h05, 24'h0F0E0D);
        pixel("coll_new", 4'b0001, 1'b0, 16'h0005, 24'h0F0E0D, 1'b0, 6'h0, 24'h0);

        // Reset mid-stream with layer 1 flashing; reset-time palette write is ignored
        flash_req = 4'b0010;
        tick();
        flash_req = '0;
        check("ms_busy", 32'(flash_busy), 32'h2);
        layer_hit = 4'b0010;
        layer_idx = 16'h0030;
        tick(); tick(); tick(); tick();
        check("ms_stream_a", 32'(vga), 32'hEDCBA9);
        tick();
        check("ms_stream_b", 32'(vga), 32'hEDCBA9);
        Reset     = 1'b1;
        pal_we    = 1'b1;
        pal_addr  = 6'h13;
        pal_wdata = 24'hFFFFFF;
        tick();
        Reset  = 1'b0;
        pal_we = 1'b0;
        check("ms_rst_vga", 32'(vga), 32'(BG));
        check("ms_rst_busy", 32'(flash_busy), 32'h0);
        tick();
        check("ms_refill1", 32'(vga), 32'(BG));
        tick();
        check("ms_refill2", 32'(vga), 32'(BG));
        tick();
        check("ms_refill3", 32'(vga), 32'(BG));
        tick();
        check("ms_refill4", 32'(vga), 32'h123456);
        layer_hit = '0;
        layer_idx = '0;
        tick(); tick(); tick(); tick();
        check("ms_idle", 32'(vga), 32'(BG));
        pixel("retain05", 4'b0001, 1'b0, 16'h0005, 24'h0F0E0D, 1'b0, 6'h0, 24'h0);
        pixel("retain27", 4'b0100, 1'b0, 16'h0700, 24'h445566, 1'b0, 6'h0, 24'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer_color_mapper.md
LAYER_COLOR_MAPPER -- requirements
Module: layer_color_mapper

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_LAYERS, 4: sprite layers; range 1..8; layer 0 has highest priority.
- IDX_W, 4: palette index width per layer; index 0 means transparent.
- ROM_LAT, 2: cycles from the hit input to the external sprite-ROM index; range 0..4.
- FLASH_FRAMES, 8: frames in a hit-flash effect; range 1..255.
- BG_COLOR, 24'h0000FF: background RGB.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- Clk, in, 1: sole clock; all logic is rising-edge.
- Reset, in, 1: synchronous, active-high reset.
- frame_start, in, 1: one-cycle pulse at start of frame.
- blank, in, 1: pixel outside the visible area; aligned with layer_hit.
- layer_hit, in, NUM_LAYERS: pixel lies inside layer k's bounding box.
- layer_idx, in, NUM_LAYERS*IDX_W: layer k's palette index in bits [k*IDX_W +: IDX_W]; valid ROM_LAT cycles after the matching layer_hit.
- pal_we, in, 1: palette write strobe.
- pal_addr, in, log2(NUM_LAYERS)+IDX_W: palette address {layer, idx}.
- pal_wdata, in, 24: RGB write data.
- flash_req, in, NUM_LAYERS: start a flash on layer k.
- flash_busy, out, NUM_LAYERS: flash counter of layer k is nonzero.
- VGA_R, VGA_G, VGA_B, out, 8 each: registered pixel colour.

Function
REQ-003 Pixel pipeline latency SHALL be ROM_LAT+2 cycles: the colour for hit/blank sampled at cycle t appears on VGA_* at cycle t+ROM_LAT+2, one pixel per cycle, with no stalls.
REQ-004 blank and layer_hit SHALL be delayed ROM_LAT cycles internally so they align with layer_idx; for ROM_LAT=0 there is no delay.
REQ-005 A layer k SHALL be opaque at a pixel iff its delayed hit is 1 and its index is nonzero.
REQ-006 The winner SHALL be the lowest-numbered opaque layer; the winning layer number, index and an "any opaque" flag SHALL be registered (stage 1).
REQ-007 Stage 2 SHALL read palette entry {winner, index} and register the output colour.
REQ-008 With no opaque layer, the output SHALL be BG_COLOR.
REQ-009 With delayed blank=1, the output SHALL be 24'h000000, regardless of hits.
REQ-010 The palette SHALL hold NUM_LAYERS*2^IDX_W entries of 24 bits; entry {k,0} is never displayed.
REQ-011 A palette write SHALL take effect at the Clk edge on which pal_we=1.
REQ-012 A read of the same address on that same edge SHALL return the old data.
REQ-013 Each layer SHALL have an 8-bit flash counter.
- flash_req[k]=1 loads FLASH_FRAMES, including when the counter is already busy (restart).
- Otherwise frame_start decrements a nonzero counter.
- flash_req and frame_start in the same cycle: load wins.
- The counter saturates at 0.
REQ-014 When the winning layer's counter is nonzero and its bit 0 is 1, the output SHALL be the bitwise inverse of the palette colour; blank and background are never inverted.
REQ-015 flash_busy[k] SHALL be registered and equal (counter_k != 0).
REQ-016 The flash state used for a pixel SHALL be the counter value at stage 2.

Reset
REQ-017 Reset SHALL force VGA_* to BG_COLOR, clear all pipeline valid/hit/blank stages to 0 (so background is output), clear all flash counters and flash_busy to 0.
REQ-018 During Reset, pal_we SHALL be ignored.
REQ-019 Palette contents SHALL be unaffected by Reset.
REQ-020 Reset asserted mid-frame SHALL produce BG_COLOR from the next edge onward.
REQ-021 After Reset deasserts, output SHALL be BG_COLOR until the first pixel sampled after reset reaches the output (ROM_LAT+2 cycles).

Verification
REQ-022 Latency and background (defaults): write {1,3}=24'h123456; pulse layer_hit=4'b0010 at cycle t; present idx=3 at t+2.
- Required: VGA=12/34/56 exactly at t+4.
- Required: 00/00/FF on the cycles before and after.
REQ-023 Priority and transparency:
- Layers 0 and 2 hit, idx0=5, idx2=7 -> colour {0,5}.
- Same stimulus with idx0=0 -> colour {2,7}.
- All indices 0 -> 00/00/FF.
REQ-024 Blank: blank=1 with layer 0 opaque -> 00/00/00 at t+4.
REQ-025 Flash: FLASH_FRAMES=3, flash_req[0] pulse, then frame_start pulses.
- flash_busy[0]=1 for exactly 3 frame_starts, then 0.
- Layer-0 pixels are inverted while the counter is 3 and 1, normal while it is 2 and 0.
- flash_req coincident with frame_start reloads to 3.
REQ-026 Palette write-read collision: pal_we to {0,5} on the same edge that stage 2 reads {0,5}.
- Old value output on that pixel.
- New value on the next such pixel.
REQ-027 Reset mid-stream: Reset for 1 cycle during continuous hits.
- VGA=00/00/FF and flash_busy=0 on the next edge.
- Palette retains written values after reset.
